// File: rtl/accel_mem_pkg.sv
// Shared definitions for the accelerator memory channels: per-channel
// geometry, the RAM controller state encoding and the byte-lane merge helper.
package accel_mem_pkg;

  // Channel geometry (data width, external address width, stored words)
  localparam int A_DATA_W = 64;
  localparam int A_ADDR_W = 12;
  localparam int A_DEPTH  = 4096;
  localparam int B_DATA_W = 64;
  localparam int B_ADDR_W = 14;
  localparam int B_DEPTH  = 16384;
  localparam int C_DATA_W = 256;
  localparam int C_ADDR_W = 10;
  localparam int C_DEPTH  = 1024;
  localparam int D_DATA_W = 64;
  localparam int D_ADDR_W = 9;
  localparam int D_DEPTH  = 512;

  // Widest word any channel uses; the merge helper works at this width
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    MEM_IDLE  = 1'b0,
    MEM_CLEAR = 1'b1
  } mem_state_e;

  // Replace each byte lane of old_w with new_w where the lane enable is set
  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/accel_rd_pipe.sv
// Read-response delay line: RD_LAT stages of valid/data. The data of a stage
// only moves when a valid word moves into it, so the last stage holds the
// most recent response while nothing new arrives.
module accel_rd_pipe #(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  // Next-stage values: shift valid every cycle, move data only with valid
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    if (in_valid) dat_d[0] = in_data;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) dat_d[k] = dat_q[k-1];
    end
  end

  // Stage registers, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];

endmodule

// File: rtl/accel_bram_model.sv
// Single-port block-RAM model with configurable read latency, byte-lane
// writes, read-first/write-first response, out-of-range detection and a
// hardware zero sweep. Every accepted access (read or write) produces one
// rd_valid pulse RD_LAT cycles after the cycle it was presented in.
// Handshake: an access is taken in any cycle where en=1 and busy=0; there is
// no back-pressure, so the requester never has to wait beyond watching busy.
module accel_bram_model
  import accel_mem_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 32,
  parameter int RD_LAT         = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  input  logic                en,
  input  logic                we,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   dout,
  output logic                rd_valid,
  output logic                busy,
  output logic                oob,
  output mem_state_e          state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam mem_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? MEM_CLEAR : MEM_IDLE;

  logic [DATA_W-1:0] mem_q [DEPTH];

  mem_state_e        state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              oob_q, oob_d;

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              accept;
  logic              acc_wr;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_data;

  assign idx = addr[IDX_W-1:0];

  // Upper address bits must all be zero for an in-range access
  if (IDX_W < ADDR_W) begin : g_range_chk
    assign in_range = (addr[ADDR_W-1:IDX_W] == '0);
  end else begin : g_range_full
    assign in_range = 1'b1;
  end

  assign accept      = en && (state_q == MEM_IDLE);
  assign acc_wr      = accept && we && in_range;
  assign old_word    = mem_q[idx];
  assign merged_word = DATA_W'(merge_be(MAX_DATA_W'(old_word), MAX_DATA_W'(din),
                                        MAX_BE_W'(be)));

  // Response word captured at acceptance; out-of-range reads return zero
  always_comb begin
    rd_data = old_word;
    if (!in_range)                    rd_data = '0;
    else if ((WRITE_FIRST != 0) && we) rd_data = merged_word;
  end

  // Controller next state: clear sweep walks every index exactly once
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    oob_d     = accept && !in_range;
    case (state_q)
      MEM_IDLE: begin
        if (clr_req) begin
          state_d   = MEM_CLEAR;
          clr_idx_d = '0;
        end
      end
      MEM_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d   = MEM_IDLE;
          clr_idx_d = '0;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Controller registers; reset restarts any sweep from index 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RESET_STATE;
      clr_idx_q <= '0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      oob_q     <= oob_d;
    end
  end

  // Storage array: sweep zeroes one word per cycle, else lane-merged writes
  always_ff @(posedge clk) begin
    if (state_q == MEM_CLEAR) mem_q[clr_idx_q] <= '0;
    else if (acc_wr)          mem_q[idx]       <= merged_word;
  end

  accel_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst),
    .in_valid  (accept),
    .in_data   (rd_data),
    .out_valid (rd_valid),
    .out_data  (dout)
  );

  assign busy      = (state_q == MEM_CLEAR);
  assign oob       = oob_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_accel_bram_model.sv
// Directed bench for accel_bram_model. Two instances share all inputs:
// u_lat1 (RD_LAT=1, read-first) and u_lat3 (RD_LAT=3, write-first), so each
// access checks both latencies and both write-response modes.
module tb_accel_bram_model;
  import accel_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [63:0] din;
  logic [7:0]  be;
  logic        en, we, clr_req;

  logic [63:0] dout1, dout3;
  logic        rv1, rv3, busy1, busy3, oob1, oob3;
  mem_state_e  st1, st3;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] W_A  = 64'h0101000001000101;
  localparam logic [63:0] W_M  = 64'h01010000FFFFFFFF;
  localparam logic [63:0] W_5  = 64'h5555_AAAA_1234_5678;
  localparam logic [63:0] W_31 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] W_7  = 64'h0F0E_0D0C_0B0A_0908;
  localparam logic [63:0] W_9  = 64'h9999_0000_9999_0000;
  localparam logic [63:0] W_3B = 64'h3333_4444_5555_6666;

  // clock/reset
  always #5 clk = ~clk;

  accel_bram_model #(.DATA_W(64), .ADDR_W(12), .DEPTH(32), .RD_LAT(1),
                     .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .be(be), .en(en), .we(we),
    .clr_req(clr_req), .dout(dout1), .rd_valid(rv1), .busy(busy1), .oob(oob1),
    .state_dbg(st1));

  accel_bram_model #(.DATA_W(64), .ADDR_W(12), .DEPTH(32), .RD_LAT(3),
                     .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_lat3 (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .be(be), .en(en), .we(we),
    .clr_req(clr_req), .dout(dout3), .rd_valid(rv3), .busy(busy3), .oob(oob3),
    .state_dbg(st3));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated access; e1/e3 are the responses expected from each instance
  task automatic access(input logic [11:0] a, input logic [63:0] d, input logic [7:0] b,
                        input logic w, input logic [63:0] e1, input logic [63:0] e3,
                        input logic eo);
    @(negedge clk);
    addr = a; din = d; be = b; we = w; en = 1'b1;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
    chk("v1", rv1, 1'b1);
    chk("d1", dout1, e1);
    chk("oob1", oob1, eo);
    chk("oob3", oob3, eo);
    chk("v3_early1", rv3, 1'b0);
    @(negedge clk);
    chk("v1_pulse", rv1, 1'b0);
    chk("oob1_pulse", oob1, 1'b0);
    chk("v3_early2", rv3, 1'b0);
    @(negedge clk);
    chk("v3", rv3, 1'b1);
    chk("d3", dout3, e3);
    chk("d1_hold", dout1, e1);
  endtask

  // Counts cycles with busy high, starting at the current negedge
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n, p1, p3, po;

  initial begin
    rst = 1'b0; addr = '0; din = '0; be = '0; en = 1'b0; we = 1'b0; clr_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_dout1", dout1, 64'h0);
    chk("rst_dout3", dout3, 64'h0);
    chk("rst_rv1", rv1, 1'b0);
    chk("rst_oob1", oob1, 1'b0);
    chk("rst_busy1", busy1, 1'b1);
    chk("rst_busy3", busy3, 1'b1);
    chk("rst_state", st1, MEM_CLEAR);

    // Initial sweep lasts exactly DEPTH cycles
    rst = 1'b1;
    count_busy(n);
    chk("init_sweep_len", n, 32);
    chk("idle_state", st3, MEM_IDLE);
    access(12'd5, 64'h0, 8'h00, 1'b0, 64'h0, 64'h0, 1'b0);

    // Full-word write then readback
    access(12'd3, W_A, 8'hFF, 1'b1, 64'h0, W_A, 1'b0);
    access(12'd3, 64'h0, 8'h00, 1'b0, W_A, W_A, 1'b0);

    // Partial lane write: read-first returns old, write-first returns merged
    access(12'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1, W_A, W_M, 1'b0);
    access(12'd3, 64'h0, 8'h00, 1'b0, W_M, W_M, 1'b0);
    // be=0 write changes nothing
    access(12'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 1'b1, W_M, W_M, 1'b0);
    access(12'd3, 64'h0, 8'h00, 1'b0, W_M, W_M, 1'b0);

    // Out-of-range aliasing onto index 5 must not corrupt it
    access(12'd5, W_5, 8'hFF, 1'b1, 64'h0, W_5, 1'b0);
    access(12'h025, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'h0, 64'h0, 1'b1);
    access(12'd5, 64'h0, 8'h00, 1'b0, W_5, W_5, 1'b0);
    access(12'h025, 64'h0, 8'h00, 1'b0, 64'h0, 64'h0, 1'b1);
    // Top index and first out-of-range address
    access(12'd31, W_31, 8'hFF, 1'b1, 64'h0, W_31, 1'b0);
    access(12'd31, 64'h0, 8'h00, 1'b0, W_31, W_31, 1'b0);
    access(12'h020, 64'h0, 8'h00, 1'b0, 64'h0, 64'h0, 1'b1);

    // Back-to-back write then read of the same address
    @(negedge clk);
    addr = 12'd7; din = W_7; be = 8'hFF; we = 1'b1; en = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("b2b_v1_wr", rv1, 1'b1);
    chk("b2b_d1_wr", dout1, 64'h0);
    @(negedge clk);
    en = 1'b0;
    chk("b2b_v1_rd", rv1, 1'b1);
    chk("b2b_d1_rd", dout1, W_7);
    chk("b2b_v3_early", rv3, 1'b0);
    @(negedge clk);
    chk("b2b_v3_wr", rv3, 1'b1);
    chk("b2b_d3_wr", dout3, W_7);
    @(negedge clk);
    chk("b2b_v3_rd", rv3, 1'b1);
    chk("b2b_d3_rd", dout3, W_7);
    @(negedge clk);
    chk("b2b_v3_end", rv3, 1'b0);
    chk("b2b_d3_hold", dout3, W_7);

    // Write together with clr_req, then en held high through the sweep
    @(negedge clk);
    addr = 12'd9; din = W_9; be = 8'hFF; we = 1'b1; en = 1'b1; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0; we = 1'b0;
    chk("clr_wr_d1", dout1, 64'h0);
    n = 0; p1 = 0; p3 = 0; po = 0;
    while (busy1 && n < 100) begin
      n++;
      p1 += int'(rv1);
      p3 += int'(rv3);
      po += int'(oob1 | oob3);
      @(negedge clk);
    end
    en = 1'b0;
    chk("clr_sweep_len", n, 32);
    chk("clr_rv1_pulses", p1, 1);
    chk("clr_rv3_pulses", p3, 1);
    chk("clr_oob_pulses", po, 0);
    chk("clr_d3_wr", dout3, W_9);
    access(12'd9, 64'h0, 8'h00, 1'b0, 64'h0, 64'h0, 1'b0);
    access(12'd3, 64'h0, 8'h00, 1'b0, 64'h0, 64'h0, 1'b0);

    // Reset in the middle of a sweep
    access(12'd3, W_3B, 8'hFF, 1'b1, 64'h0, W_3B, 1'b0);
    access(12'd3, 64'h0, 8'h00, 1'b0, W_3B, W_3B, 1'b0);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    chk("mid_busy", busy1, 1'b1);
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_dout1", dout1, 64'h0);
    chk("mid_rst_dout3", dout3, 64'h0);
    chk("mid_rst_rv3", rv3, 1'b0);
    chk("mid_rst_busy", busy1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    count_busy(n);
    chk("restart_sweep_len", n, 32);
    access(12'd3, 64'h0, 8'h00, 1'b0, 64'h0, 64'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accel_bram_model.md
Name: accel_bram_model

Overview:
- Parametrised single-port block-RAM model for the accelerator's memory channels A/B/C/D.
- One instance per channel replaces ad-hoc per-bench memory arrays; also usable as a synthesizable scratch RAM.
- Extends the basic fixed 1-cycle, whole-word, aliased-address RAM with:
  - configurable read latency
  - byte-lane write enables
  - read-first/write-first selection
  - out-of-range detection
  - a hardware clear sweep

Parameters:
DATA_W, 64, data word width in bits; multiple of 8 (64 for A/B/D, 256 for C)
ADDR_W, 12, external address width (12/14/10/9 per channel)
DEPTH, 32, stored words; power of two, 2..2**ADDR_W; IDX_W = log2(DEPTH)
RD_LAT, 1, read latency in cycles, 1..4
WRITE_FIRST, 0, 0 = read-first (dout shows old word on write), 1 = write-first (dout shows merged new word)
CLEAR_ON_RESET, 1, 1 = run the zero sweep after reset release, 0 = contents undefined after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
addr  input  ADDR_W  word address
din  input  DATA_W  write data
be  input  DATA_W/8  byte-lane write enables; bit i covers din[8i+7:8i]
en  input  1  access request this cycle
we  input  1  write qualifier; valid only with en
clr_req  input  1  single-cycle request to zero all DEPTH words
dout  output  DATA_W  read data
rd_valid  output  1  pulses when dout carries a completed access
busy  output  1  clear sweep in progress; accesses ignored
oob  output  1  one-cycle pulse: accepted access had addr >= DEPTH

Behaviour:
- Reset (rst=0, asynchronous):
  - dout=0, rd_valid=0, oob=0.
  - Latency pipeline cleared.
  - State forced to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy reflects the forced state immediately.
  - Memory array is not reset directly.
- State machine:
  - IDLE: accepts accesses; clr_req=1 -> CLEAR next cycle.
  - CLEAR: writes zero to word idx, idx increments each cycle from 0. After idx=DEPTH-1 is written -> IDLE. Sweep takes exactly DEPTH cycles.
- busy=1 exactly while in CLEAR.
- In CLEAR:
  - en and clr_req are ignored: no write, no rd_valid, no oob.
  - Reset asserted mid-sweep restarts the sweep from idx 0.
- Accepted access = en=1 in IDLE, including the cycle clr_req is sampled. Sweep starts the following cycle.
- Index: idx = addr[IDX_W-1:0]. If addr[ADDR_W-1:IDX_W] != 0 the access is out-of-range:
  - write dropped
  - read data forced to 0
  - oob=1 in the cycle after acceptance
  - rd_valid still issued
- Write (en & we): for each lane i with be[i]=1, mem[idx] lane i <= din lane i; other lanes keep their value. we with be=0 is a legal no-op write.
- Read data for every accepted access (read or write), sampled at acceptance:
  - read-first: pre-write word
  - write-first: lane-merged word
- Latency: acceptance at edge N -> dout and rd_valid=1 valid after edge N+RD_LAT.
  - Pipeline is RD_LAT deep.
  - Back-to-back accesses give back-to-back rd_valid pulses.
- dout holds its last value when rd_valid=0; it never returns to 0 except on reset.
- Same-address write followed by read in the next cycle returns the written data (no hazard window).
- Sweep writes do not generate rd_valid.

Decomposition:
- Shared package accel_mem_pkg:
  - per-channel constants (DATA_W/ADDR_W/DEPTH for A, B, C, D)
  - state enum {MEM_IDLE, MEM_CLEAR}
  - lane-merge function merge_be(old, new, be)
- Sub-module accel_rd_pipe holds the RD_LAT-stage valid/data shift register (asynchronous active-low reset); the top keeps array, FSM and oob logic.

Test Plan:
1. Reset release, DEPTH=32, CLEAR_ON_RESET=1 -> busy=1 for exactly 32 cycles. Then read addr 5 -> dout=0, rd_valid one cycle later.
2. Write addr 3, din=64'h0101000001000101, be=8'hFF; read addr 3 next cycle, RD_LAT=1 -> dout=64'h0101000001000101. Repeat with RD_LAT=3 -> rd_valid exactly 3 cycles after each acceptance.
3. Word at addr 3 = 64'h0101000001000101; write din=64'hFFFF_FFFF_FFFF_FFFF, be=8'h0F:
   - readback -> 64'h01010000FFFFFFFF
   - write response: WRITE_FIRST=0 -> old word; WRITE_FIRST=1 -> merged word
4. ADDR_W=12, DEPTH=32:
   - write addr 12'h025 (idx 5) -> oob pulse, mem[5] unchanged.
   - read addr 12'h025 -> dout=0, rd_valid=1, oob=1.
5. clr_req with en & we in the same IDLE cycle -> write lands, then 32-cycle sweep. en asserted during sweep -> no rd_valid. Final readback of the written address -> 0.
6. rst driven low at sweep idx 10 -> outputs zero asynchronously. After release, sweep restarts and busy lasts a full 32 cycles.
